pixel_plot_sink: RTL



---
 rtl/pixel_plot_sink.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/pixel_plot_sink.sv
// pixel_plot_sink: receiving end of the plot interface used by the drawing FSMs.
// Each draw_en cycle is one plot request. The request is bounds-checked and turned
// into a linear framebuffer address, then queued in a small FIFO. A write FSM
// drains the FIFO into the framebuffer port with a we/ready handshake. The
// drawing side never stalls: requests that are out of bounds, or that arrive
// while the queue is full, are dropped and counted in a saturating counter.
// Optional feature macro: PIXEL_PLOT_SINK_CLEAR_EN adds a full-screen clear.

module pixel_plot_sink #(
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 120,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 15,
    parameter int COLOUR_W   = 3
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                draw_en,
    input  logic [7:0]          x,
    input  logic [7:0]          y,
    input  logic [COLOUR_W-1:0] colour,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [COLOUR_W-1:0] mem_data,
    output logic                mem_we,
    input  logic                mem_ready,
`ifdef PIXEL_PLOT_SINK_CLEAR_EN
    input  logic                clear_req,
    input  logic [COLOUR_W-1:0] clear_colour,
`endif
    output logic                fifo_full,
    output logic                busy,
    output logic [7:0]          drop_count
);

    localparam int              PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [8:0]      WIDTH_LIM  = 9'(WIDTH);
    localparam logic [8:0]      HEIGHT_LIM = 9'(HEIGHT);
    localparam logic [PTR_W:0]  DEPTH_CNT  = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]  ONE_CNT    = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

`ifdef PIXEL_PLOT_SINK_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH*HEIGHT-1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CLEAR
    } state_t;
`else
    typedef enum logic [0:0] {
        ST_IDLE,
        ST_ISSUE
    } state_t;
`endif

    // Queue storage: the head entry stays in the queue until its write is accepted.
    logic [ADDR_W-1:0]   addr_mem [FIFO_DEPTH];
    logic [COLOUR_W-1:0] col_mem  [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    rd_ptr_nxt;
    logic [PTR_W:0]      count;

    logic                in_bounds;
    logic                push;
    logic                pop;
    logic                drop;
    logic [ADDR_W-1:0]   push_addr;

    state_t              state;
    state_t              state_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [COLOUR_W-1:0] mem_data_d;
    logic                mem_we_d;

`ifdef PIXEL_PLOT_SINK_CLEAR_EN
    logic                clear_pending;
    logic [COLOUR_W-1:0] clear_col_q;
    logic                clear_start;
`endif

    // Fullness is the registered flag, so a pop on the same edge cannot rescue a push.
    assign in_bounds  = ({1'b0, x} < WIDTH_LIM) && ({1'b0, y} < HEIGHT_LIM);
    assign push       = draw_en && in_bounds && !fifo_full;
    assign drop       = draw_en && !push;
    assign push_addr  = ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x);
    assign rd_ptr_nxt = rd_ptr + PTR_ONE;

`ifdef PIXEL_PLOT_SINK_CLEAR_EN
    assign busy = (count != '0) || mem_we || clear_pending || (state == ST_CLEAR);
`else
    assign busy = (count != '0) || mem_we;
`endif

    // Queue payload storage; written only on an accepted push, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= push_addr;
            col_mem[wr_ptr]  <= colour;
        end
    end

    // Queue pointers, occupancy count and the registered full flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            fifo_full <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_nxt;
            end
            case ({push, pop})
                2'b10: begin
                    count     <= count + ONE_CNT;
                    fifo_full <= (count == DEPTH_CNT - ONE_CNT);
                end
                2'b01: begin
                    count     <= count - ONE_CNT;
                    fifo_full <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Saturating count of discarded plot requests.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drop_count <= 8'd0;
        end else if (drop && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
        end
    end

`ifdef PIXEL_PLOT_SINK_CLEAR_EN
    // Latch a clear request and its colour; requests during an active clear are ignored.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clear_pending <= 1'b0;
            clear_col_q   <= '0;
        end else if (clear_req && (state != ST_CLEAR)) begin
            clear_pending <= 1'b1;
            clear_col_q   <= clear_colour;
        end else if (clear_start) begin
            clear_pending <= 1'b0;
        end
    end
`endif

    // Write FSM state and the registered framebuffer port.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            mem_addr <= '0;
            mem_data <= '0;
            mem_we   <= 1'b0;
        end else begin
            state    <= state_d;
            mem_addr <= mem_addr_d;
            mem_data <= mem_data_d;
            mem_we   <= mem_we_d;
        end
    end

    // Next-state logic: load the head, hold while stalled, chain the next entry on accept.
    always_comb begin
        state_d    = state;
        mem_addr_d = mem_addr;
        mem_data_d = mem_data;
        mem_we_d   = mem_we;
        pop        = 1'b0;
`ifdef PIXEL_PLOT_SINK_CLEAR_EN
        clear_start = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (count != '0) begin
                    mem_addr_d = addr_mem[rd_ptr];
                    mem_data_d = col_mem[rd_ptr];
                    mem_we_d   = 1'b1;
                    state_d    = ST_ISSUE;
                end
`ifdef PIXEL_PLOT_SINK_CLEAR_EN
                else if (clear_pending) begin
                    mem_addr_d  = '0;
                    mem_data_d  = clear_col_q;
                    mem_we_d    = 1'b1;
                    clear_start = 1'b1;
                    state_d     = ST_CLEAR;
                end
`endif
            end
            ST_ISSUE: begin
                if (mem_ready) begin
                    pop = 1'b1;
                    if (count > ONE_CNT) begin
                        mem_addr_d = addr_mem[rd_ptr_nxt];
                        mem_data_d = col_mem[rd_ptr_nxt];
                    end else if (push) begin
                        mem_addr_d = push_addr;
                        mem_data_d = colour;
                    end else begin
                        mem_we_d = 1'b0;
                        state_d  = ST_IDLE;
                    end
                end
            end
`ifdef PIXEL_PLOT_SINK_CLEAR_EN
            ST_CLEAR: begin
                if (mem_ready) begin
                    if (mem_addr == LAST_ADDR) begin
                        mem_we_d = 1'b0;
                        state_d  = ST_IDLE;
                    end else begin
                        mem_addr_d = mem_addr + ADDR_W'(1);
                    end
                end
            end
`endif
            default: begin
                mem_we_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

endmodule
